// File: rtl/wb_write_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// Widths mirror the core's RegBus / RegNumLog2 definitions.
package wb_write_arbiter_pkg;

  localparam int RegBus      = 32;
  localparam int RegNumLog2  = 5;
  localparam int WbArbDepth  = 2;

  localparam logic [RegNumLog2-1:0] RegAddrBus = '0;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic [RegBus-1:0]     ZeroWord    = '0;

  // Which source owns the write slot this cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2,
    SEL_LU   = 2'd3
  } wb_sel_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the write sources, the arbiter and the register file.
// lu_valid/lu_ready: a beat transfers on any clock edge where both are high; while
// lu_valid is high and lu_ready low the source holds lu_waddr/lu_wdata stable.
interface wb_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                     pipe_we;
  logic [ADDR_W-1:0]        pipe_waddr;
  logic [DATA_W-1:0]        pipe_wdata;
  logic                     lu_valid;
  logic                     lu_ready;
  logic [ADDR_W-1:0]        lu_waddr;
  logic [DATA_W-1:0]        lu_wdata;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [(1<<ADDR_W)-1:0]   pend_mask;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
    input  lu_ready, we, waddr, wdata, pend_mask
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata, lu_valid, lu_waddr, lu_wdata,
    output lu_ready, we, waddr, wdata, pend_mask
  );
endinterface

// File: rtl/wb_squash_fifo.sv
// Small FIFO of pending long-latency writes; entries can be killed by address
// while in flight and still occupy their slot until popped.
module wb_squash_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegNumLog2,
  parameter int DEPTH  = WbArbDepth
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          push_live,
  input  logic [ADDR_W-1:0]             push_addr,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  input  logic                          squash_en,
  input  logic [ADDR_W-1:0]             squash_addr,
  output logic                          empty,
  output logic                          full,
  output logic                          head_live,
  output logic [ADDR_W-1:0]             head_addr,
  output logic [DATA_W-1:0]             head_data,
  output logic [DEPTH-1:0]              live,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] entry_data [DEPTH];

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_live = live[rd_ptr];
  assign head_addr = entry_addr[rd_ptr];
  assign head_data = entry_data[rd_ptr];

  // Live bits are cleared on pop so that free slots never match a squash or
  // contribute to the pending mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      live   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && live[i] && (entry_addr[i] == squash_addr))
          live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + PW'(1);
      end
      if (push) begin
        live[wr_ptr] <= push_live;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[wr_ptr] <= push_addr;
      entry_data[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writes first, buffered long-latency
// results next, direct pass-through last. Optional counters under WB_ARB_STATS_EN.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DATA_W = RegBus,
  parameter int ADDR_W = RegNumLog2,
  parameter int DEPTH  = WbArbDepth
) (
  input  logic                 clk,
  input  logic                 rst,
  wb_write_arbiter_if.slave    bus
`ifdef WB_ARB_STATS_EN
  ,
  output logic [31:0]          stat_stall_cnt,
  output logic [31:0]          stat_squash_cnt
`endif
);

  localparam int NREG = 1 << ADDR_W;

  logic                         fifo_empty, fifo_full;
  logic                         head_live;
  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0]             fifo_live;
  logic [DEPTH-1:0][ADDR_W-1:0] fifo_addr;

  logic              pipe_hit, lu_xfer, push, pop, push_live, lu_same_addr;
  wb_sel_e           sel;
  logic              nxt_we;
  logic [ADDR_W-1:0] nxt_waddr;
  logic [DATA_W-1:0] nxt_wdata;

  assign pipe_hit     = bus.pipe_we && (bus.pipe_waddr != '0);
  assign bus.lu_ready = !fifo_full;
  assign lu_xfer      = bus.lu_valid && bus.lu_ready;
  assign lu_same_addr = pipe_hit && (bus.lu_waddr == bus.pipe_waddr);

  always_comb begin
    sel = SEL_NONE;
    if (pipe_hit)           sel = SEL_PIPE;
    else if (!fifo_empty)   sel = SEL_FIFO;
    else if (bus.lu_valid)  sel = SEL_LU;
  end

  always_comb begin
    nxt_we    = 1'b0;
    nxt_waddr = '0;
    nxt_wdata = '0;
    case (sel)
      SEL_PIPE: begin
        nxt_we    = WriteEnable;
        nxt_waddr = bus.pipe_waddr;
        nxt_wdata = bus.pipe_wdata;
      end
      SEL_FIFO: if (head_live) begin
        nxt_we    = WriteEnable;
        nxt_waddr = head_addr;
        nxt_wdata = head_data;
      end
      SEL_LU: if (bus.lu_waddr != '0) begin
        nxt_we    = WriteEnable;
        nxt_waddr = bus.lu_waddr;
        nxt_wdata = bus.lu_wdata;
      end
      default: ;
    endcase
  end

  // A same-cycle pipeline write to the same register is younger, so the beat is
  // stored dead; address 0 beats also take a slot but never write.
  assign pop       = (sel == SEL_FIFO);
  assign push      = lu_xfer && (sel != SEL_LU);
  assign push_live = (bus.lu_waddr != '0) && !lu_same_addr;

  wb_squash_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_live   (push_live),
    .push_addr   (bus.lu_waddr),
    .push_data   (bus.lu_wdata),
    .pop         (pop),
    .squash_en   (pipe_hit),
    .squash_addr (bus.pipe_waddr),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .head_live   (head_live),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .live        (fifo_live),
    .entry_addr  (fifo_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= ZeroWord[DATA_W-1:0];
    end else begin
      bus.we    <= nxt_we;
      bus.waddr <= nxt_waddr;
      bus.wdata <= nxt_wdata;
    end
  end

  always_comb begin
    bus.pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live[i]) bus.pend_mask[fifo_addr[i]] = 1'b1;
    end
  end

`ifdef WB_ARB_STATS_EN
  logic [31:0] squash_inc;

  always_comb begin
    squash_inc = '0;
    if (pipe_hit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_live[i] && (fifo_addr[i] == bus.pipe_waddr)) squash_inc = squash_inc + 32'd1;
      end
    end
    if (push && lu_same_addr) squash_inc = squash_inc + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cnt  <= '0;
      stat_squash_cnt <= '0;
    end else begin
      if (bus.lu_valid && !bus.lu_ready)
        stat_stall_cnt <= sat_add32(stat_stall_cnt, 32'd1);
      stat_squash_cnt <= sat_add32(stat_squash_cnt, squash_inc);
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed and random stimulus for wb_write_arbiter against a queue-based model
// of the write-merge, squash and pending-mask rules.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;
  localparam int NREG   = 1 << ADDR_W;
  localparam int EW     = 1 + ADDR_W + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef WB_ARB_STATS_EN
  logic [31:0] stat_stall_cnt, stat_squash_cnt;
`endif

  wb_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_stall_cnt  (stat_stall_cnt),
    .stat_squash_cnt (stat_squash_cnt)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                live;
  } ent_t;

  ent_t              m_q[$];
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] rf [NREG];
  int                checks = 0;
  int                errors = 0;
  int unsigned       m_stall = 0;
  int unsigned       m_squash = 0;
  bit                m_xfer = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG-1:0] model_pend();
    logic [NREG-1:0] p;
    p = '0;
    foreach (m_q[i]) if (m_q[i].live) p[m_q[i].addr] = 1'b1;
    return p;
  endfunction

  task automatic drive(input logic pwe, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld);
    bus.pipe_we    = pwe;
    bus.pipe_waddr = pa;
    bus.pipe_wdata = pd;
    bus.lu_valid   = lv;
    bus.lu_waddr   = la;
    bus.lu_wdata   = ld;
  endtask

  // One clock: check pre-edge status, predict the write, advance, check it.
  task automatic cycle();
    logic [EW-1:0]     e;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    bit                ready, hit, pass;
    ent_t              n;

    ready = (m_q.size() < DEPTH);
    chk("lu_ready", {63'd0, bus.lu_ready}, {63'd0, ready});
    chk("pend_mask", 64'(bus.pend_mask), 64'(model_pend()));

    hit    = bus.pipe_we && (bus.pipe_waddr != 0);
    m_xfer = bus.lu_valid && ready;
    pass   = 1'b0;
    e_we   = 1'b0;
    e_addr = '0;
    e_data = '0;
    if (bus.lu_valid && !ready) m_stall++;

    if (hit) begin
      e_we = 1'b1; e_addr = bus.pipe_waddr; e_data = bus.pipe_wdata;
    end else if (m_q.size() > 0) begin
      n = m_q.pop_front();
      if (n.live) begin e_we = 1'b1; e_addr = n.addr; e_data = n.data; end
    end else if (bus.lu_valid) begin
      pass = 1'b1;
      if (bus.lu_waddr != 0) begin e_we = 1'b1; e_addr = bus.lu_waddr; e_data = bus.lu_wdata; end
    end

    if (hit) begin
      foreach (m_q[i]) begin
        if (m_q[i].live && m_q[i].addr == bus.pipe_waddr) begin
          m_q[i].live = 1'b0;
          m_squash++;
        end
      end
    end
    if (m_xfer && !pass) begin
      n.addr = bus.lu_waddr;
      n.data = bus.lu_wdata;
      n.live = (bus.lu_waddr != 0) && !(hit && bus.lu_waddr == bus.pipe_waddr);
      if (hit && bus.lu_waddr == bus.pipe_waddr) m_squash++;
      m_q.push_back(n);
    end
    exp_q.push_back({e_we, e_addr, e_data});

    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("we", {63'd0, bus.we}, {63'd0, e[EW-1]});
    if (e[EW-1]) begin
      chk("waddr", 64'(bus.waddr), 64'(e[EW-2:DATA_W]));
      chk("wdata", 64'(bus.wdata), 64'(e[DATA_W-1:0]));
    end
    if (bus.we === 1'b1) rf[bus.waddr] = bus.wdata;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    m_q.delete();
    exp_q.delete();
    m_stall = 0;
    m_squash = 0;
    m_xfer = 1'b0;
    chk("rst_we", {63'd0, bus.we}, 64'd0);
    chk("rst_waddr", 64'(bus.waddr), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_pend", 64'(bus.pend_mask), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", {63'd0, bus.lu_ready}, 64'd1);
    chk("post_rst_we", {63'd0, bus.we}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf[i] = '0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Pipeline only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    chk("pipe_we", {63'd0, bus.we}, 64'd1);
    chk("pipe_wdata", 64'(bus.wdata), 64'hDEADBEEF);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // Pass-through
    drive(0, 0, 0, 1, 7, 32'h11);
    cycle();
    chk("pass_pend7", {63'd0, bus.pend_mask[7]}, 64'd0);
    chk("pass_ready", {63'd0, bus.lu_ready}, 64'd1);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // Buffer fill and drain
    drive(1, 1, 32'h101, 1, 3, 32'h33);
    cycle();
    drive(1, 2, 32'h202, 1, 4, 32'h44);
    cycle();
    chk("fill_ready", {63'd0, bus.lu_ready}, 64'd0);
    chk("fill_pend", 64'(bus.pend_mask), 64'h18);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("drain1_pend", 64'(bus.pend_mask), 64'h10);
    cycle();
    chk("drain2_ready", {63'd0, bus.lu_ready}, 64'd1);
    cycle();

    // Squash
    drive(1, 1, 32'h1, 1, 9, 32'hAA);
    cycle();
    chk("sq_pend9_set", {63'd0, bus.pend_mask[9]}, 64'd1);
    drive(1, 9, 32'hBB, 0, 0, 0);
    cycle();
    chk("sq_pend9_clr", {63'd0, bus.pend_mask[9]}, 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("sq_drain_we", {63'd0, bus.we}, 64'd0);
    cycle();
    chk("sq_rf9", 64'(rf[9]), 64'hBB);

    // Zero register
    drive(1, 0, 32'h5, 1, 0, 32'h6);
    cycle();
    chk("zero_we", {63'd0, bus.we}, 64'd0);
    drive(1, 1, 32'h7, 1, 0, 32'h8);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("zero_slot_we", {63'd0, bus.we}, 64'd0);

    // Reset mid-drain
    drive(1, 1, 32'h1, 1, 3, 32'h3);
    cycle();
    drive(1, 2, 32'h2, 1, 4, 32'h4);
    cycle();
    chk("pre_rst_pend", 64'(bus.pend_mask), 64'h18);
    do_reset();
    repeat (3) cycle();

    // Random traffic
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      if (!(bus.lu_valid && !m_xfer)) begin
        bus.lu_valid = ($urandom_range(0, 2) != 0);
        bus.lu_waddr = ADDR_W'($urandom_range(0, 7));
        bus.lu_wdata = $urandom;
      end
      bus.pipe_we    = ($urandom_range(0, 99) < ((c % 100) < 60 ? 70 : 20));
      bus.pipe_waddr = ADDR_W'($urandom_range(0, 7));
      bus.pipe_wdata = $urandom;
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

`ifdef WB_ARB_STATS_EN
    chk("stat_stall", 64'(stat_stall_cnt), 64'(m_stall));
    chk("stat_squash", 64'(stat_squash_cnt), 64'(m_squash));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
